elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Request scheduler and car sequencer for the elevator. It latches floor-call pulses from the per-floor button debouncers into a pending-request register. It then drives a single car between floors using a SCAN policy: keep the current direction while any request lies ahead, otherwise reverse. It owns current-floor position, direction, the door timer and request clearing, and feeds the floor display and door/motor outputs.

## Interface
Parameters:
- FLOORS, 4, number of floors (≥2); floors numbered 0..FLOORS-1
- FLOOR_W, 2, width of floor index, = clog2(FLOORS)
- TRAVEL_CYCLES, 8, clock cycles to travel one floor (≥1)
- DOOR_CYCLES, 4, clock cycles door stays open per stop (≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  FLOORS  one-cycle call pulses from button blocks; bit i = call to floor i; multiple bits may be high at once
- pending  out  FLOORS  latched outstanding requests
- cur_floor  out  FLOOR_W  last floor reached (binary)
- dir_up  out  1  current/last travel direction, 1 = up
- moving  out  1  high while in MOVE
- door_open  out  1  high while in DOOR
- arrived  out  1  one-cycle pulse on the first DOOR cycle of each stop

## Operation
- Reset values: state IDLE, pending=0, cur_floor=0, dir_up=1, moving=0, door_open=0, arrived=0, both timers 0.
- Request latch: pending[i] <= 1 on any cycle with req[i]=1.
  - Exception: req[cur_floor] while in DOOR is dropped.
  - Clear beats set in the same cycle for the bit being serviced.
- ahead_up = any pending bit above cur_floor; ahead_dn = any pending bit below.
- IDLE, evaluated in priority order:
  - pending[cur_floor]=1: go to DOOR (arrived pulses).
  - dir_up=1: ahead_up -> MOVE up; else ahead_dn -> MOVE down, dir_up<=0.
  - dir_up=0: ahead_dn -> MOVE down; else ahead_up -> MOVE up, dir_up<=1.
  - No pending bits: stay in IDLE; dir_up holds.
- MOVE:
  - Travel timer counts 0..TRAVEL_CYCLES-1.
  - On the edge ending the last count, cur_floor steps ±1 per dir_up and the timer restarts.
  - If pending[new floor]=1, enter DOOR on that same edge; otherwise stay in MOVE in the same direction.
  - A request always remains ahead, because bits clear only in DOOR.
  - cur_floor never leaves 0..FLOORS-1; a step past the end is a design error, and the bench asserts it never happens.
- DOOR:
  - On entry, pending[cur_floor] clears and the door timer loads.
  - door_open=1 for exactly DOOR_CYCLES cycles, then IDLE.
  - A door stop always passes through IDLE for one cycle before moving again.
- Requests for the floor the car is passing, latched after its arrival edge, are served on a later pass.
- reset mid-operation, in any state, returns every register to its reset value on the next edge; pending requests are lost.

## Timing
- req at edge N: pending visible from cycle N+1.
- IDLE decision takes one cycle: pending set at N+1 gives moving=1 from N+2.
- Each floor takes TRAVEL_CYCLES cycles in MOVE.
- cur_floor, arrived, door_open and pending-clear all change on the same edge.
- Door-open latency from an idle car at floor f to floor g≠f: 1 + |g−f|·TRAVEL_CYCLES cycles after pending is visible.
- Request at the car's own floor while IDLE: door_open one cycle after pending is visible.
- All outputs are registered; no combinational path from req to any output.

## Test plan
- Reset then req=4'b0100 pulse at cycle 0 (defaults):
  - pending=0100 at cycle 1; moving=1 cycles 2..17; cur_floor=1 at 10, 2 at 18.
  - arrived and door_open rise at 18, pending=0 at 18; door_open falls at 22; IDLE at 22.
- Idle at floor 0, req[0] pulse: door_open=1 for 4 cycles starting cycle 2; cur_floor stays 0; moving never rises.
- Car moving up from 0 toward 3 with req[3] pending; req[1] while cur_floor=0 and req[0] at the same time:
  - stops at 1, then 3, then reverses and stops at 0; dir_up=0 after the stop at 3.
- Simultaneous req=4'b1010 from IDLE at floor 2, dir_up=1:
  - serves 3 first, then 1; pending goes 1010 -> 0010 -> 0000.
- req[2] pulsed while door open at floor 2: dropped, pending[2] stays 0, door timer not restarted.
- reset asserted mid-MOVE between floors 1 and 2 with pending=1100: next cycle all outputs at reset values, pending=0, cur_floor=0.

Source files
------------

// File: rtl/elevator_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | elevator_scheduler: SCAN-policy request latch and single-car sequencer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module elevator_scheduler #(
   parameter int FLOORS        = 4,
   parameter int FLOOR_W       = 2,
   parameter int TRAVEL_CYCLES = 8,
   parameter int DOOR_CYCLES   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  req,
   output logic [FLOORS-1:0]  pending,
   output logic [FLOOR_W-1:0] cur_floor,
   output logic               dir_up,
   output logic               moving,
   output logic               door_open,
   output logic               arrived
);
   localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_DOOR = 2'd2
   } state_t;

   state_t             r_state;
   logic [FLOORS-1:0]  r_pending;
   logic [FLOOR_W-1:0] r_cur_floor;
   logic               r_dir_up;
   logic               r_moving;
   logic               r_door_open;
   logic               r_arrived;
   logic [TW-1:0]      r_travel_cnt;
   logic [DW-1:0]      r_door_cnt;

   logic               w_ahead_up;
   logic               w_ahead_dn;
   logic [FLOOR_W-1:0] w_next_floor;
   logic [FLOORS-1:0]  w_cur_onehot;
   logic [FLOORS-1:0]  w_next_onehot;
   logic [FLOORS-1:0]  w_drop;
   logic [FLOORS-1:0]  w_clr;
   logic               w_here;
   logic               w_next_hit;
   logic               w_travel_done;

   always_comb begin
      w_ahead_up = 1'b0;
      w_ahead_dn = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (r_pending[i] && (FLOOR_W'(i) > r_cur_floor)) w_ahead_up = 1'b1;
         if (r_pending[i] && (FLOOR_W'(i) < r_cur_floor)) w_ahead_dn = 1'b1;
      end
   end

   assign w_next_floor  = r_dir_up ? (r_cur_floor + FLOOR_W'(1)) : (r_cur_floor - FLOOR_W'(1));
   assign w_cur_onehot  = FLOORS'(1) << r_cur_floor;
   assign w_next_onehot = FLOORS'(1) << w_next_floor;
   assign w_here        = r_pending[r_cur_floor];
   assign w_next_hit    = r_pending[w_next_floor];
   assign w_travel_done = (r_travel_cnt == TW'(TRAVEL_CYCLES - 1));

   // Calls for the floor whose door is open are already being served.
   assign w_drop = (r_state == S_DOOR) ? w_cur_onehot : '0;

   always_comb begin
      w_clr = '0;
      if (r_state == S_IDLE && w_here)
         w_clr = w_cur_onehot;
      else if (r_state == S_MOVE && w_travel_done && w_next_hit)
         w_clr = w_next_onehot;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_pending    <= '0;
         r_cur_floor  <= '0;
         r_dir_up     <= 1'b1;
         r_moving     <= 1'b0;
         r_door_open  <= 1'b0;
         r_arrived    <= 1'b0;
         r_travel_cnt <= '0;
         r_door_cnt   <= '0;
      end else begin
         r_pending <= (r_pending | (req & ~w_drop)) & ~w_clr;
         r_arrived <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_here) begin
                  r_state     <= S_DOOR;
                  r_door_open <= 1'b1;
                  r_arrived   <= 1'b1;
                  r_door_cnt  <= DW'(DOOR_CYCLES - 1);
               end else if (w_ahead_up && (r_dir_up || !w_ahead_dn)) begin
                  r_state      <= S_MOVE;
                  r_moving     <= 1'b1;
                  r_dir_up     <= 1'b1;
                  r_travel_cnt <= '0;
               end else if (w_ahead_dn) begin
                  r_state      <= S_MOVE;
                  r_moving     <= 1'b1;
                  r_dir_up     <= 1'b0;
                  r_travel_cnt <= '0;
               end
            end
            S_MOVE: begin
               if (w_travel_done) begin
                  r_travel_cnt <= '0;
                  r_cur_floor  <= w_next_floor;
                  if (w_next_hit) begin
                     r_state     <= S_DOOR;
                     r_moving    <= 1'b0;
                     r_door_open <= 1'b1;
                     r_arrived   <= 1'b1;
                     r_door_cnt  <= DW'(DOOR_CYCLES - 1);
                  end
               end else begin
                  r_travel_cnt <= r_travel_cnt + TW'(1);
               end
            end
            S_DOOR: begin
               if (r_door_cnt == '0) begin
                  r_state     <= S_IDLE;
                  r_door_open <= 1'b0;
               end else begin
                  r_door_cnt <= r_door_cnt - DW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pending   = r_pending;
   assign cur_floor = r_cur_floor;
   assign dir_up    = r_dir_up;
   assign moving    = r_moving;
   assign door_open = r_door_open;
   assign arrived   = r_arrived;
endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// Testbench for elevator_scheduler: directed scenarios plus random calls,
// checked against a trip-level reference model through an expectation queue.
module tb_elevator_scheduler;
   localparam int FLOORS        = 4;
   localparam int FLOOR_W       = 2;
   localparam int TRAVEL_CYCLES = 8;
   localparam int DOOR_CYCLES   = 4;
   localparam int OW            = FLOORS + FLOOR_W + 4;

   localparam int M_IDLE = 0;
   localparam int M_MOVE = 1;
   localparam int M_DOOR = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [FLOORS-1:0]  req = '0;
   logic [FLOORS-1:0]  pending;
   logic [FLOOR_W-1:0] cur_floor;
   logic               dir_up;
   logic               moving;
   logic               door_open;
   logic               arrived;

   always #5 clk = ~clk;

   elevator_scheduler #(
      .FLOORS(FLOORS), .FLOOR_W(FLOOR_W),
      .TRAVEL_CYCLES(TRAVEL_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .req(req),
      .pending(pending), .cur_floor(cur_floor), .dir_up(dir_up),
      .moving(moving), .door_open(door_open), .arrived(arrived)
   );

   logic [OW-1:0] exp_q[$];
   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // Reference car: a trip-level description (cycles left on the current
   // floor leg, cycles left with the door open) rather than counters.
   bit [FLOORS-1:0] m_pend;
   int              m_floor;
   bit              m_up;
   int              m_mode;
   int              m_tleft;
   int              m_dleft;
   bit              m_arr;

   function automatic logic [OW-1:0] model_outputs();
      return {m_pend, FLOOR_W'(m_floor), m_up, (m_mode == M_MOVE), (m_mode == M_DOOR), m_arr};
   endfunction

   function automatic void model_step(input bit [FLOORS-1:0] r, input bit rst);
      bit [FLOORS-1:0] incoming;
      bit [FLOORS-1:0] nxt;
      bit              above;
      bit              below;
      int              clear;
      if (rst) begin
         m_pend = '0; m_floor = 0; m_up = 1'b1; m_mode = M_IDLE;
         m_tleft = 0; m_dleft = 0; m_arr = 1'b0;
         return;
      end
      incoming = r;
      if (m_mode == M_DOOR) incoming[m_floor] = 1'b0;
      nxt   = m_pend | incoming;
      clear = -1;
      m_arr = 1'b0;
      above = 1'b0;
      below = 1'b0;
      for (int f = 0; f < FLOORS; f++) begin
         if (m_pend[f] && f > m_floor) above = 1'b1;
         if (m_pend[f] && f < m_floor) below = 1'b1;
      end
      case (m_mode)
         M_IDLE: begin
            if (m_pend[m_floor]) begin
               m_mode = M_DOOR; m_dleft = DOOR_CYCLES; m_arr = 1'b1; clear = m_floor;
            end else if (above || below) begin
               if (m_up) m_up = above;
               else      m_up = !below;
               m_mode  = M_MOVE;
               m_tleft = TRAVEL_CYCLES;
            end
         end
         M_MOVE: begin
            m_tleft--;
            if (m_tleft == 0) begin
               m_floor = m_up ? m_floor + 1 : m_floor - 1;
               m_tleft = TRAVEL_CYCLES;
               if (m_pend[m_floor]) begin
                  m_mode = M_DOOR; m_dleft = DOOR_CYCLES; m_arr = 1'b1; clear = m_floor;
               end
            end
         end
         default: begin
            m_dleft--;
            if (m_dleft == 0) m_mode = M_IDLE;
         end
      endcase
      if (clear >= 0) nxt[clear] = 1'b0;
      m_pend = nxt;
   endfunction

   task automatic cycle(input logic [FLOORS-1:0] r, input bit rst);
      req   = r;
      reset = rst;
      model_step(r, rst);
      exp_q.push_back(model_outputs());
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle('0, 1'b0);
   endtask

   task automatic do_reset();
      cycle('0, 1'b1);
      cycle('0, 1'b1);
   endtask

   always @(negedge clk) begin
      logic [OW-1:0] e;
      logic [OW-1:0] a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {pending, cur_floor, dir_up, moving, door_open, arrived};
         compared++;
         if (a !== e) begin
            mismatched++;
            $display("FAIL outputs cyc=%0d {pend,floor,up,mov,door,arr} got=%b expected=%b",
                     cyc, a, e);
         end
      end
      cyc++;
   end

   // A car moving toward a floor that does not exist means it stepped off the end.
   always @(negedge clk) begin
      if (!reset) begin
         assert (!(moving && dir_up && cur_floor == FLOOR_W'(FLOORS - 1)))
            else $error("car moving up from the top floor");
         assert (!(moving && !dir_up && cur_floor == '0))
            else $error("car moving down from floor 0");
      end
   end

   initial begin
      // Single call two floors up from reset.
      do_reset();
      cycle(4'b0100, 1'b0);
      idle(26);
      // Call at the car's own floor while idle.
      do_reset();
      cycle(4'b0001, 1'b0);
      idle(8);
      // Calls to 1 and 0 appear while the car leaves floor 0 for 3.
      do_reset();
      cycle(4'b1000, 1'b0);
      idle(3);
      cycle(4'b0011, 1'b0);
      idle(80);
      // Simultaneous calls above and below an idle car at floor 2.
      do_reset();
      cycle(4'b0100, 1'b0);
      idle(25);
      cycle(4'b1010, 1'b0);
      idle(60);
      // Own-floor call while the door is open is dropped.
      do_reset();
      cycle(4'b0100, 1'b0);
      idle(19);
      cycle(4'b0100, 1'b0);
      idle(8);
      // Reset between floors 1 and 2 with two calls outstanding.
      do_reset();
      cycle(4'b1100, 1'b0);
      idle(12);
      cycle('0, 1'b1);
      idle(5);
      // Randomized traffic with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         logic [FLOORS-1:0] r;
         bit                rs;
         r  = ($urandom_range(0, 7) == 0) ? FLOORS'($urandom_range(1, (1 << FLOORS) - 1)) : '0;
         rs = ($urandom_range(0, 499) == 0);
         cycle(r, rs);
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
